// File: rtl/umbral_pkg.sv
// Shared constants for the flow-control controller and its FIFO responders.
package umbral_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } ctrl_state_t;

  localparam int THR_W     = 4;
  localparam int NUM_FIFOS = 5;
  localparam int AF_DEF    = 6;
  localparam int AE_DEF    = 1;

endpackage

// File: rtl/fifo_mem.sv
// Register-file storage for the FIFO: one synchronous write port, one registered read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset; the array keeps stale contents.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_umbral.sv
// Single-clock FIFO with init-loaded almost-full/almost-empty thresholds and sticky error.
module fifo_umbral
  import umbral_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_DEFAULT = AF_DEF,
  parameter int AE_DEFAULT = AE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [THR_W-1:0]      umbral_alto,
  input  logic [THR_W-1:0]      umbral_bajo,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int CMP_W = (CNT_W > THR_W) ? CNT_W : THR_W;

  if (ADDR_WIDTH > 4) begin : g_depth_check
    $error("fifo_umbral: ADDR_WIDTH must be <= 4");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [THR_W-1:0]      thr_alto, thr_bajo;
  logic                  push_ok, pop_ok, fault;

  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  assign almost_full  = CMP_W'(count) >= CMP_W'(thr_alto);
  assign almost_empty = CMP_W'(count) <= CMP_W'(thr_bajo);

  // Pop frees a slot in the same edge, so a full FIFO still accepts push+pop.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign fault   = (push && full && !pop) || (pop && empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
      thr_alto  <= THR_W'(AF_DEFAULT);
      thr_bajo  <= THR_W'(AE_DEFAULT);
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      valid_out <= pop_ok;
      if (fault) error <= 1'b1;
      if (init) begin
        thr_alto <= umbral_alto;
        thr_bajo <= umbral_bajo;
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (reset),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule
